// File: rtl/vpp_avg.sv
// vpp_avg: running mean of the last 2**avg_log2 peak-to-peak window results.
// Defining VPP_AVG_MID_EN adds a (max+min)/2 midpoint path averaged in lockstep.
module vpp_avg #(
    parameter int data_bit_width = 12,
    parameter int avg_log2       = 3
) (
    input  logic                      clk_fs,
    input  logic                      rst,
    input  logic                      irq,
    input  logic [data_bit_width-1:0] vpp,
    input  logic                      clear,
`ifdef VPP_AVG_MID_EN
    input  logic [data_bit_width-1:0] max,
    input  logic [data_bit_width-1:0] min,
    output logic [data_bit_width-1:0] mid_avg,
`endif
    output logic [data_bit_width-1:0] avg,
    output logic                      avg_valid,
    output logic                      filled,
    output logic [avg_log2:0]         sample_cnt
);

    localparam int DEPTH = 1 << avg_log2;
    localparam int SUM_W = data_bit_width + avg_log2;

    typedef logic [SUM_W-1:0]          sum_t;
    typedef logic [data_bit_width-1:0] data_t;
    typedef logic [avg_log2-1:0]       ptr_t;
    typedef logic [avg_log2:0]         cnt_t;

    localparam ptr_t PTR_STEP = ptr_t'(1);
    localparam cnt_t CNT_STEP = cnt_t'(1);
    localparam cnt_t CNT_LAST = cnt_t'(DEPTH - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic       state;
    logic       irq_d;
    logic       capture;
    data_t      vpp_cap;
    logic       cap_vld;
    logic       upd_vld;
    logic       commit;
    sum_t       sum;
    ptr_t       wr_ptr;
    data_t      old_vpp;
    data_t      hist_mem [DEPTH];

    assign capture = irq & ~irq_d;
    assign filled  = (state == ST_RUN);
    assign commit  = cap_vld & ~clear & ~rst;

    // Until the window is full the slot being overwritten holds stale data,
    // so its contribution to the sum is masked to zero.
    assign old_vpp = filled ? hist_mem[wr_ptr] : '0;

    always_ff @(posedge clk_fs) begin
        if (rst) begin
            irq_d   <= 1'b0;
            cap_vld <= 1'b0;
            vpp_cap <= '0;
        end else if (clear) begin
            irq_d   <= irq;
            cap_vld <= 1'b0;
        end else begin
            irq_d   <= irq;
            cap_vld <= capture;
            if (capture) begin
                vpp_cap <= vpp;
            end
        end
    end

    always_ff @(posedge clk_fs) begin
        if (commit) begin
            hist_mem[wr_ptr] <= vpp_cap;
        end
    end

    always_ff @(posedge clk_fs) begin
        if (rst || clear) begin
            sum        <= '0;
            wr_ptr     <= '0;
            sample_cnt <= '0;
            upd_vld    <= 1'b0;
        end else begin
            upd_vld <= cap_vld;
            if (cap_vld) begin
                sum    <= sum + sum_t'(vpp_cap) - sum_t'(old_vpp);
                wr_ptr <= wr_ptr + PTR_STEP;
                if (state == ST_FILL) begin
                    sample_cnt <= sample_cnt + CNT_STEP;
                end
            end
        end
    end

    // Leaving RUN is only possible through clear or rst.
    always_ff @(posedge clk_fs) begin
        if (rst || clear) begin
            state <= ST_FILL;
        end else begin
            case (state)
                ST_FILL: begin
                    if (cap_vld && sample_cnt == CNT_LAST) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_fs) begin
        if (rst) begin
            avg       <= '0;
            avg_valid <= 1'b0;
        end else if (clear) begin
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (upd_vld && filled) begin
                avg       <= sum[SUM_W-1:avg_log2];
                avg_valid <= 1'b1;
            end
        end
    end

`ifdef VPP_AVG_MID_EN
    data_t mid_half;
    data_t mid_cap;
    data_t mid_old;
    sum_t  mid_sum;
    data_t mid_mem [DEPTH];

    // One extra bit on the add keeps max+min from wrapping before the halving.
    assign mid_half = data_t'(({1'b0, max} + {1'b0, min}) >> 1);
    assign mid_old  = filled ? mid_mem[wr_ptr] : '0;

    always_ff @(posedge clk_fs) begin
        if (rst) begin
            mid_cap <= '0;
        end else if (!clear && capture) begin
            mid_cap <= mid_half;
        end
    end

    always_ff @(posedge clk_fs) begin
        if (commit) begin
            mid_mem[wr_ptr] <= mid_cap;
        end
    end

    always_ff @(posedge clk_fs) begin
        if (rst || clear) begin
            mid_sum <= '0;
        end else if (cap_vld) begin
            mid_sum <= mid_sum + sum_t'(mid_cap) - sum_t'(mid_old);
        end
    end

    always_ff @(posedge clk_fs) begin
        if (rst) begin
            mid_avg <= '0;
        end else if (!clear && upd_vld && filled) begin
            mid_avg <= mid_sum[SUM_W-1:avg_log2];
        end
    end
`endif

endmodule

// File: tb/tb_vpp_avg.sv
// tb_vpp_avg: directed test-plan scenarios plus randomized irq/clear/rst traffic,
// checked every cycle against a queue-based running-mean model.
module tb_vpp_avg;

    localparam int DW = 12;
    localparam int L2 = 2;
    localparam int N  = 1 << L2;

    logic          clk_fs = 1'b0;
    logic          rst;
    logic          irq;
    logic [DW-1:0] vpp;
    logic          clear;
    logic [DW-1:0] avg;
    logic          avg_valid;
    logic          filled;
    logic [L2:0]   sample_cnt;
`ifdef VPP_AVG_MID_EN
    logic [DW-1:0] max;
    logic [DW-1:0] min;
    logic [DW-1:0] mid_avg;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vpp_avg #(.data_bit_width(DW), .avg_log2(L2)) dut (
        .clk_fs     (clk_fs),
        .rst        (rst),
        .irq        (irq),
        .vpp        (vpp),
        .clear      (clear),
`ifdef VPP_AVG_MID_EN
        .max        (max),
        .min        (min),
        .mid_avg    (mid_avg),
`endif
        .avg        (avg),
        .avg_valid  (avg_valid),
        .filled     (filled),
        .sample_cnt (sample_cnt)
    );

    always #5 clk_fs = ~clk_fs;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int mean_of(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s / N;
    endfunction

    // Reference: the history is simply the last N committed captures since
    // reset/clear; a capture commits one edge after it is seen and publishes one edge later.
    int hist[$];
    int mid_hist[$];
    bit m_irq_prev  = 1'b0;
    bit m_commit    = 1'b0;
    bit m_publish   = 1'b0;
    int m_val       = 0;
    int m_mid_val   = 0;
    int exp_avg     = 0;
    int exp_mid     = 0;
    bit exp_valid   = 1'b0;
    bit model_ready = 1'b0;

    always @(posedge clk_fs) begin
        bit new_cap;
        new_cap = irq && !m_irq_prev;
        if (rst) begin
            hist.delete();
            mid_hist.delete();
            exp_avg     = 0;
            exp_mid     = 0;
            exp_valid   = 1'b0;
            m_commit    = 1'b0;
            m_publish   = 1'b0;
            m_irq_prev  = 1'b0;
            model_ready = 1'b1;
        end else if (clear) begin
            hist.delete();
            mid_hist.delete();
            exp_valid  = 1'b0;
            m_commit   = 1'b0;
            m_publish  = 1'b0;
            m_irq_prev = irq;
        end else begin
            exp_valid = 1'b0;
            if (m_publish && hist.size() == N) begin
                exp_valid = 1'b1;
                exp_avg   = mean_of(hist);
                exp_mid   = mean_of(mid_hist);
            end
            if (m_commit) begin
                hist.push_back(m_val);
                mid_hist.push_back(m_mid_val);
                if (hist.size() > N) begin
                    void'(hist.pop_front());
                    void'(mid_hist.pop_front());
                end
            end
            m_publish = m_commit;
            m_commit  = new_cap;
            if (new_cap) begin
                m_val = int'(vpp);
`ifdef VPP_AVG_MID_EN
                m_mid_val = (int'(max) + int'(min)) / 2;
`endif
            end
            m_irq_prev = irq;
        end
    end

    always @(negedge clk_fs) begin
        if (model_ready) begin
            checkOutput("avg", int'(avg), exp_avg);
            checkOutput("avg_valid", int'(avg_valid), int'(exp_valid));
            checkOutput("filled", int'(filled), (hist.size() == N) ? 1 : 0);
            checkOutput("sample_cnt", int'(sample_cnt), hist.size());
`ifdef VPP_AVG_MID_EN
            checkOutput("mid_avg", int'(mid_avg), exp_mid);
`endif
        end
    end

    // One capture pulse; returns at the negedge after P+2, when avg_valid is due.
    task automatic applyStimulus(input int v, input int mx, input int mn);
        @(negedge clk_fs);
        irq = 1'b1;
        vpp = DW'(v);
`ifdef VPP_AVG_MID_EN
        max = DW'(mx);
        min = DW'(mn);
`else
        if (mx < 0 || mn < 0) $display("[TB] negative midpoint operands ignored");
`endif
        @(negedge clk_fs);
        irq = 1'b0;
        @(negedge clk_fs);
        @(negedge clk_fs);
    endtask

    task automatic pulseClear();
        @(negedge clk_fs);
        clear = 1'b1;
        @(negedge clk_fs);
        clear = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        irq   = 1'b0;
        vpp   = '0;
        clear = 1'b0;
`ifdef VPP_AVG_MID_EN
        max = '0;
        min = '0;
`endif
        repeat (3) @(negedge clk_fs);
        checkOutput("reset_avg", int'(avg), 0);
        checkOutput("reset_valid", int'(avg_valid), 0);
        checkOutput("reset_filled", int'(filled), 0);
        checkOutput("reset_cnt", int'(sample_cnt), 0);
        rst = 1'b0;

        applyStimulus(100, 0, 0);
        checkOutput("fill1_valid", int'(avg_valid), 0);
        checkOutput("fill1_cnt", int'(sample_cnt), 1);
        applyStimulus(200, 0, 0);
        checkOutput("fill2_valid", int'(avg_valid), 0);
        applyStimulus(300, 0, 0);
        checkOutput("fill3_valid", int'(avg_valid), 0);
        checkOutput("fill3_cnt", int'(sample_cnt), 3);
        applyStimulus(400, 0, 0);
        checkOutput("first_valid", int'(avg_valid), 1);
        checkOutput("first_avg", int'(avg), 250);
        checkOutput("first_filled", int'(filled), 1);
        checkOutput("model_avg_250", exp_avg, 250);
        applyStimulus(500, 0, 0);
        checkOutput("slide_avg", int'(avg), 350);
        checkOutput("slide_valid", int'(avg_valid), 1);

        pulseClear();
        checkOutput("clear_filled", int'(filled), 0);
        checkOutput("clear_cnt", int'(sample_cnt), 0);
        checkOutput("clear_avg_hold", int'(avg), 350);
        applyStimulus(10, 0, 0);
        applyStimulus(20, 0, 0);
        applyStimulus(30, 0, 0);
        checkOutput("refill_no_valid", int'(avg_valid), 0);
        applyStimulus(40, 0, 0);
        checkOutput("refill_avg", int'(avg), 25);
        checkOutput("refill_valid", int'(avg_valid), 1);

        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(2, 0, 0);
        checkOutput("trunc_avg", int'(avg), 1);
        for (int i = 0; i < 4; i++) applyStimulus(4095, 0, 0);
        checkOutput("fullscale_avg", int'(avg), 4095);
        checkOutput("model_fullscale", exp_avg, 4095);

        pulseClear();
        @(negedge clk_fs);
        irq = 1'b1;
        vpp = DW'(700);
        repeat (50) @(negedge clk_fs);
        checkOutput("held_irq_cnt", int'(sample_cnt), 1);
        irq = 1'b0;
        @(negedge clk_fs);
        irq = 1'b1;
        repeat (4) @(negedge clk_fs);
        checkOutput("retoggle_cnt", int'(sample_cnt), 2);
        irq = 1'b0;

        @(negedge clk_fs);
        clear = 1'b1;
        irq   = 1'b1;
        vpp   = DW'(999);
        @(negedge clk_fs);
        clear = 1'b0;
        repeat (3) @(negedge clk_fs);
        checkOutput("clear_edge_cnt", int'(sample_cnt), 0);
        checkOutput("clear_edge_avg", int'(avg), 4095);
        irq = 1'b0;

        applyStimulus(60, 0, 0);
        applyStimulus(70, 0, 0);
        applyStimulus(80, 0, 0);
        @(negedge clk_fs);
        irq = 1'b1;
        vpp = DW'(50);
        @(negedge clk_fs);
        irq   = 1'b0;
        clear = 1'b1;
        @(negedge clk_fs);
        clear = 1'b0;
        @(negedge clk_fs);
        checkOutput("clear_p1_valid", int'(avg_valid), 0);
        checkOutput("clear_p1_cnt", int'(sample_cnt), 0);

        applyStimulus(11, 0, 0);
        applyStimulus(22, 0, 0);
        checkOutput("midfill_cnt", int'(sample_cnt), 2);
        @(negedge clk_fs);
        rst = 1'b1;
        @(negedge clk_fs);
        rst = 1'b0;
        checkOutput("rst_avg", int'(avg), 0);
        checkOutput("rst_valid", int'(avg_valid), 0);
        checkOutput("rst_filled", int'(filled), 0);
        checkOutput("rst_cnt", int'(sample_cnt), 0);

`ifdef VPP_AVG_MID_EN
        for (int i = 0; i < 4; i++) applyStimulus(123, 3000, 1000);
        checkOutput("mid_avg_2000", int'(mid_avg), 2000);
`endif

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_fs);
            irq   = ($urandom_range(0, 2) == 0);
            clear = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 999) == 0);
            if (!irq) begin
                vpp = DW'($urandom_range(0, 4095));
`ifdef VPP_AVG_MID_EN
                max = DW'($urandom_range(0, 4095));
                min = DW'($urandom_range(0, 4095));
`endif
            end
        end
        irq   = 1'b0;
        clear = 1'b0;
        rst   = 1'b0;
        repeat (5) @(negedge clk_fs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
